id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have a parameter XLEN, default 64, giving the PC, register-data and immediate width.
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have the port reset, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 SHALL have the port stall, input, 1 bit: hold all stored contents (load-use hazard).
REQ-005 SHALL have the port flush, input, 1 bit: insert a bubble (branch taken or mispredict).
REQ-006 SHALL have the ports id_ALUOp (input, 2 bits) and id_BranchEq, id_BranchGt, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite (input, 1 bit each): control from the decode stage.
REQ-007 SHALL have the ports id_PC, id_ReadData1, id_ReadData2, id_Imm, input, XLEN bits each: decode-stage datapath values.
REQ-008 SHALL have the ports id_rs1, id_rs2, id_rd, input, 5 bits each: register indices.
REQ-009 SHALL have the port id_Funct, input, 4 bits: {funct7[5], funct3} for ALU control.
REQ-010 SHALL have the port id_valid, input, 1 bit: the decode stage holds a real instruction.
REQ-011 SHALL have an ex_* output, registered, for every id_* input above, each of identical width.
REQ-012 SHALL have the port bubble_count, output, 16 bits: the saturating count of bubbles inserted.

Function
REQ-013 SHALL update on each rising clk edge when reset is high, with priority flush > stall > load.
REQ-014 SHALL, on load (flush=0, stall=0), capture every id_* input into its ex_* output, giving one-cycle latency.
REQ-015 SHALL, on stall=1 and flush=0, hold every ex_* output and bubble_count unchanged.
REQ-016 SHALL, on flush=1, clear ex_RegWrite, ex_MemRead, ex_MemWrite, ex_BranchEq, ex_BranchGt and ex_valid to 0, and set ex_ALUOp to 00 and ex_MemtoReg and ex_ALUSrc to 0.
REQ-017 SHALL, on flush=1, clear ex_rd, ex_rs1 and ex_rs2 to 0; datapath fields (PC, ReadData1/2, Imm, Funct) are don't-care and SHALL be cleared to 0 for determinism.
REQ-018 SHALL treat flush=1 and stall=1 in the same cycle as a flush: a bubble is inserted and the stalled content is discarded.
REQ-019 SHALL, on a load with id_valid=0, capture the bubble as-is and force ex_RegWrite, ex_MemWrite, ex_MemRead, ex_BranchEq and ex_BranchGt to 0 regardless of their id_* values.
REQ-020 SHALL increment bubble_count by 1 on each edge where a bubble is inserted (flush=1, or a load with id_valid=0).
REQ-021 SHALL saturate bubble_count at 16'hFFFF with no wrap-around.
REQ-022 SHALL not increment bubble_count during stall cycles.
REQ-023 SHALL accept X on any MemtoReg input only when the corresponding RegWrite input is 0, and SHALL still register the value.
REQ-024 SHALL contain no combinational path from any input to any output.

Reset
REQ-025 SHALL, on reset low, immediately and independently of clk, drive all ex_* outputs to 0 (ex_ALUOp = 00, ex_valid = 0) and bubble_count to 0.
REQ-026 SHALL, when reset is asserted mid-operation (including during a stall), discard the held contents, and the first edge after reset release SHALL perform a normal load/stall/flush.
REQ-027 SHALL have the reset deassertion synchronised externally; the block adds no synchronizer.

Verification
REQ-028 SHALL pass a reset test: drive reset low between edges -> all outputs 0 before the next edge, and bubble_count = 0.
REQ-029 SHALL pass a load test: R-type (ALUOp=10, RegWrite=1, rd=5, ReadData1=64'h10, ReadData2=64'h20, id_valid=1) -> identical values on ex_* one edge later, and bubble_count unchanged.
REQ-030 SHALL pass a stall test: load lw (MemRead=1, MemtoReg=1, rd=7), then stall=1 for 3 cycles while the id_* inputs change -> ex_* hold the lw values for all 3 cycles.
REQ-031 SHALL pass a flush-over-stall test: stall=1 and flush=1 together with RegWrite=1 held -> ex_RegWrite=0, ex_rd=0, ex_valid=0, and bubble_count increments by 1.
REQ-032 SHALL pass an invalid-slot test: id_valid=0 with id_MemWrite=1 -> ex_MemWrite=0 and bubble_count increments.
REQ-033 SHALL pass a saturation test: preload the count to 16'hFFFE, apply 3 flushes -> bubble_count = 16'hFFFF after each of the last two.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: one-cycle capture of decode-stage control and datapath,
// with stall hold, flush bubble insertion and a saturating bubble counter.
module id_ex_register #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic [1:0]      id_ALUOp,
   input  logic            id_BranchEq,
   input  logic            id_BranchGt,
   input  logic            id_MemRead,
   input  logic            id_MemtoReg,
   input  logic            id_MemWrite,
   input  logic            id_ALUSrc,
   input  logic            id_RegWrite,
   input  logic [XLEN-1:0] id_PC,
   input  logic [XLEN-1:0] id_ReadData1,
   input  logic [XLEN-1:0] id_ReadData2,
   input  logic [XLEN-1:0] id_Imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [3:0]      id_Funct,
   input  logic            id_valid,
   output logic [1:0]      ex_ALUOp,
   output logic            ex_BranchEq,
   output logic            ex_BranchGt,
   output logic            ex_MemRead,
   output logic            ex_MemtoReg,
   output logic            ex_MemWrite,
   output logic            ex_ALUSrc,
   output logic            ex_RegWrite,
   output logic [XLEN-1:0] ex_PC,
   output logic [XLEN-1:0] ex_ReadData1,
   output logic [XLEN-1:0] ex_ReadData2,
   output logic [XLEN-1:0] ex_Imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [3:0]      ex_Funct,
   output logic            ex_valid,
   output logic [15:0]     bubble_count
);

   logic [1:0]      alu_op_q,   alu_op_d;
   logic            beq_q,      beq_d;
   logic            bgt_q,      bgt_d;
   logic            mem_rd_q,   mem_rd_d;
   logic            mem2reg_q,  mem2reg_d;
   logic            mem_wr_q,   mem_wr_d;
   logic            alu_src_q,  alu_src_d;
   logic            reg_wr_q,   reg_wr_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] rd1_q,      rd1_d;
   logic [XLEN-1:0] rd2_q,      rd2_d;
   logic [XLEN-1:0] imm_q,      imm_d;
   logic [4:0]      rs1_q,      rs1_d;
   logic [4:0]      rs2_q,      rs2_d;
   logic [4:0]      rd_q,       rd_d;
   logic [3:0]      funct_q,    funct_d;
   logic            valid_q,    valid_d;
   logic [15:0]     bub_cnt_q,  bub_cnt_d;
   logic            bubble;

   // Flush wins over stall; an invalid slot only counts when it is actually loaded.
   assign bubble = flush | (~stall & ~id_valid);

   always_comb begin
      alu_op_d  = alu_op_q;
      beq_d     = beq_q;
      bgt_d     = bgt_q;
      mem_rd_d  = mem_rd_q;
      mem2reg_d = mem2reg_q;
      mem_wr_d  = mem_wr_q;
      alu_src_d = alu_src_q;
      reg_wr_d  = reg_wr_q;
      pc_d      = pc_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      imm_d     = imm_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      funct_d   = funct_q;
      valid_d   = valid_q;
      bub_cnt_d = bub_cnt_q;
      if (flush) begin
         alu_op_d  = 2'b00;
         beq_d     = 1'b0;
         bgt_d     = 1'b0;
         mem_rd_d  = 1'b0;
         mem2reg_d = 1'b0;
         mem_wr_d  = 1'b0;
         alu_src_d = 1'b0;
         reg_wr_d  = 1'b0;
         pc_d      = '0;
         rd1_d     = '0;
         rd2_d     = '0;
         imm_d     = '0;
         rs1_d     = '0;
         rs2_d     = '0;
         rd_d      = '0;
         funct_d   = '0;
         valid_d   = 1'b0;
      end else if (!stall) begin
         // Side-effecting controls are gated by id_valid so a dead slot cannot write or branch.
         alu_op_d  = id_ALUOp;
         beq_d     = id_BranchEq & id_valid;
         bgt_d     = id_BranchGt & id_valid;
         mem_rd_d  = id_MemRead  & id_valid;
         mem2reg_d = id_MemtoReg;
         mem_wr_d  = id_MemWrite & id_valid;
         alu_src_d = id_ALUSrc;
         reg_wr_d  = id_RegWrite & id_valid;
         pc_d      = id_PC;
         rd1_d     = id_ReadData1;
         rd2_d     = id_ReadData2;
         imm_d     = id_Imm;
         rs1_d     = id_rs1;
         rs2_d     = id_rs2;
         rd_d      = id_rd;
         funct_d   = id_Funct;
         valid_d   = id_valid;
      end
      if (bubble && bub_cnt_q != 16'hFFFF) begin
         bub_cnt_d = bub_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_op_q  <= 2'b00;
         beq_q     <= 1'b0;
         bgt_q     <= 1'b0;
         mem_rd_q  <= 1'b0;
         mem2reg_q <= 1'b0;
         mem_wr_q  <= 1'b0;
         alu_src_q <= 1'b0;
         reg_wr_q  <= 1'b0;
         pc_q      <= '0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         imm_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         funct_q   <= '0;
         valid_q   <= 1'b0;
         bub_cnt_q <= '0;
      end else begin
         alu_op_q  <= alu_op_d;
         beq_q     <= beq_d;
         bgt_q     <= bgt_d;
         mem_rd_q  <= mem_rd_d;
         mem2reg_q <= mem2reg_d;
         mem_wr_q  <= mem_wr_d;
         alu_src_q <= alu_src_d;
         reg_wr_q  <= reg_wr_d;
         pc_q      <= pc_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         imm_q     <= imm_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
         funct_q   <= funct_d;
         valid_q   <= valid_d;
         bub_cnt_q <= bub_cnt_d;
      end
   end

   assign ex_ALUOp     = alu_op_q;
   assign ex_BranchEq  = beq_q;
   assign ex_BranchGt  = bgt_q;
   assign ex_MemRead   = mem_rd_q;
   assign ex_MemtoReg  = mem2reg_q;
   assign ex_MemWrite  = mem_wr_q;
   assign ex_ALUSrc    = alu_src_q;
   assign ex_RegWrite  = reg_wr_q;
   assign ex_PC        = pc_q;
   assign ex_ReadData1 = rd1_q;
   assign ex_ReadData2 = rd2_q;
   assign ex_Imm       = imm_q;
   assign ex_rs1       = rs1_q;
   assign ex_rs2       = rs2_q;
   assign ex_rd        = rd_q;
   assign ex_Funct     = funct_q;
   assign ex_valid     = valid_q;
   assign bubble_count = bub_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized and directed bench for id_ex_register, checked every cycle against
// a behavioural model of the pipeline slot and bubble counter.
`timescale 1ns/1ps
module tb_id_ex_register;
   localparam int XLEN = 64;

   typedef struct packed {
      logic [1:0]      aluop;
      logic            beq, bgt, mrd, m2r, mwr, asrc, rwr;
      logic [XLEN-1:0] pc, rd1, rd2, imm;
      logic [4:0]      rs1, rs2, rd;
      logic [3:0]      funct;
      logic            valid;
   } slot_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic stall = 1'b0;
   logic flush = 1'b0;
   slot_t id_s;
   slot_t ex_s;
   logic [15:0] bubble_count;

   slot_t exp_s;
   int    exp_cnt;
   int    total = 0;
   int    bad = 0;

   always #5 clk = ~clk;

   id_ex_register #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_ALUOp(id_s.aluop), .id_BranchEq(id_s.beq), .id_BranchGt(id_s.bgt),
      .id_MemRead(id_s.mrd), .id_MemtoReg(id_s.m2r), .id_MemWrite(id_s.mwr),
      .id_ALUSrc(id_s.asrc), .id_RegWrite(id_s.rwr),
      .id_PC(id_s.pc), .id_ReadData1(id_s.rd1), .id_ReadData2(id_s.rd2), .id_Imm(id_s.imm),
      .id_rs1(id_s.rs1), .id_rs2(id_s.rs2), .id_rd(id_s.rd), .id_Funct(id_s.funct),
      .id_valid(id_s.valid),
      .ex_ALUOp(ex_s.aluop), .ex_BranchEq(ex_s.beq), .ex_BranchGt(ex_s.bgt),
      .ex_MemRead(ex_s.mrd), .ex_MemtoReg(ex_s.m2r), .ex_MemWrite(ex_s.mwr),
      .ex_ALUSrc(ex_s.asrc), .ex_RegWrite(ex_s.rwr),
      .ex_PC(ex_s.pc), .ex_ReadData1(ex_s.rd1), .ex_ReadData2(ex_s.rd2), .ex_Imm(ex_s.imm),
      .ex_rs1(ex_s.rs1), .ex_rs2(ex_s.rs2), .ex_rd(ex_s.rd), .ex_Funct(ex_s.funct),
      .ex_valid(ex_s.valid),
      .bubble_count(bubble_count)
   );

   // Reference: a bubble is an all-zero slot; an invalid slot keeps its fields but
   // has no side effects; the counter counts bubbles up to 65535.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_s   <= '0;
         exp_cnt <= 0;
      end else if (flush) begin
         exp_s   <= '0;
         exp_cnt <= (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
      end else if (!stall) begin
         slot_t n;
         n = id_s;
         if (!id_s.valid) begin
            n.rwr = 1'b0; n.mwr = 1'b0; n.mrd = 1'b0; n.beq = 1'b0; n.bgt = 1'b0;
         end
         exp_s   <= n;
         exp_cnt <= (!id_s.valid && exp_cnt < 65535) ? exp_cnt + 1 : exp_cnt;
      end
   end

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_model();
      chk("slot", 320'(ex_s), 320'(exp_s));
      chk("count", 320'(bubble_count), 320'(exp_cnt));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic rand_slot();
      id_s.aluop = 2'($urandom);
      id_s.beq   = 1'($urandom); id_s.bgt  = 1'($urandom);
      id_s.mrd   = 1'($urandom); id_s.m2r  = 1'($urandom);
      id_s.mwr   = 1'($urandom); id_s.asrc = 1'($urandom);
      id_s.rwr   = 1'($urandom);
      id_s.pc    = {$urandom, $urandom};
      id_s.rd1   = {$urandom, $urandom};
      id_s.rd2   = {$urandom, $urandom};
      id_s.imm   = {$urandom, $urandom};
      id_s.rs1   = 5'($urandom); id_s.rs2 = 5'($urandom); id_s.rd = 5'($urandom);
      id_s.funct = 4'($urandom);
      id_s.valid = ($urandom_range(3, 0) != 0);
   endtask

   initial begin
      id_s = '0;
      id_s.valid = 1'b1;
      #12;
      chk("reset_slot", 320'(ex_s), 320'd0);
      chk("reset_count", 320'(bubble_count), 320'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // R-type load
      id_s = '0;
      id_s.aluop = 2'b10; id_s.rwr = 1'b1; id_s.rd = 5'd5;
      id_s.rd1 = 64'h10; id_s.rd2 = 64'h20; id_s.valid = 1'b1;
      step();
      chk("load_aluop", 320'(ex_s.aluop), 320'h2);
      chk("load_regwrite", 320'(ex_s.rwr), 320'h1);
      chk("load_rd", 320'(ex_s.rd), 320'd5);
      chk("load_rd1", 320'(ex_s.rd1), 320'h10);
      chk("load_rd2", 320'(ex_s.rd2), 320'h20);
      chk("load_count", 320'(bubble_count), 320'd0);

      // lw then 3-cycle stall with changing inputs
      id_s = '0;
      id_s.mrd = 1'b1; id_s.m2r = 1'b1; id_s.rwr = 1'b1; id_s.rd = 5'd7; id_s.valid = 1'b1;
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_slot();
         step();
         chk("stall_rd", 320'(ex_s.rd), 320'd7);
         chk("stall_memread", 320'(ex_s.mrd), 320'h1);
         chk("stall_memtoreg", 320'(ex_s.m2r), 320'h1);
      end

      // flush over stall
      flush = 1'b1; id_s.rwr = 1'b1; id_s.valid = 1'b1;
      step();
      chk("fs_regwrite", 320'(ex_s.rwr), 320'h0);
      chk("fs_rd", 320'(ex_s.rd), 320'd0);
      chk("fs_valid", 320'(ex_s.valid), 320'h0);
      chk("fs_count", 320'(bubble_count), 320'd1);

      // invalid slot
      flush = 1'b0; stall = 1'b0;
      id_s.valid = 1'b0; id_s.mwr = 1'b1;
      step();
      chk("inv_memwrite", 320'(ex_s.mwr), 320'h0);
      chk("inv_count", 320'(bubble_count), 320'd2);

      // randomized traffic with an asynchronous reset during a stall
      for (int i = 0; i < 3000; i++) begin
         rand_slot();
         flush = ($urandom_range(7, 0) == 0);
         stall = ($urandom_range(3, 0) == 0);
         if (i == 1500) begin
            stall = 1'b1;
            #2;
            reset = 1'b0;
            #1;
            chk("midreset_slot", 320'(ex_s), 320'd0);
            chk("midreset_count", 320'(bubble_count), 320'd0);
            #1;
            reset = 1'b1;
         end
         step();
      end

      // saturation: preload 65534 via flushes, then 3 more
      reset = 1'b0; #1; reset = 1'b1;
      flush = 1'b1; stall = 1'b0;
      for (int i = 0; i < 65534; i++) begin
         @(posedge clk);
      end
      #1;
      chk("sat_preload", 320'(bubble_count), 320'hFFFE);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sat_count", 320'(bubble_count), 320'hFFFF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
